// File: rtl/ber_pkg.sv
// Shared definitions for the bit-error-rate meter: tracker states and
// default parameter values used by the top level and its tap line.
package ber_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } ber_state_e;

    localparam int DEF_SEQ_LEN      = 511;
    localparam int DEF_CNT_W        = 64;
    localparam int DEF_LOCK_MAX_ERR = 8;
    localparam int DEF_LOSS_ERR     = 64;
    localparam int RELOCK_W         = 16;

endpackage

// File: rtl/ber_tap_line.sv
// Reference-bit delay line with a selectable tap. Tap k presents the
// transmitted bit delayed k+1 accepted samples (the value before this
// sample's shift).
module ber_tap_line
    import ber_pkg::*;
#(
    parameter  int SEQ_LEN = DEF_SEQ_LEN,
    localparam int SHIFT_W = $clog2(SEQ_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_shift_en,
    input  logic               i_sx,
    input  logic [SHIFT_W-1:0] i_sel,
    output logic               o_tap
);

    logic [SEQ_LEN-1:0] r_line;

    // Shift the new reference bit in at index 0 on every accepted sample.
    // NOTE: the delay line is reset because a known all-zero history is part
    // of the lock behaviour; a plain data memory would normally be left unreset.
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line <= '0;
        end else if (i_shift_en) begin
            r_line <= {r_line[SEQ_LEN-2:0], i_sx};
        end
    end

    assign o_tap = r_line[i_sel];

endmodule

// File: rtl/ber_meter.sv
// Bit-error-rate meter. Hunts for the delay between the transmitted and
// received streams by sweeping every tap of a reference delay line over
// one sequence period each, locks on the best tap, then counts compared
// bits and errors until a window shows too many errors.
module ber_meter
    import ber_pkg::*;
#(
    parameter  int SEQ_LEN      = DEF_SEQ_LEN,
    parameter  int CNT_W        = DEF_CNT_W,
    parameter  int LOCK_MAX_ERR = DEF_LOCK_MAX_ERR,
    parameter  int LOSS_ERR     = DEF_LOSS_ERR,
    localparam int SHIFT_W      = $clog2(SEQ_LEN)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                valid,
    input  logic                sx,
    input  logic                dx,
    input  logic                clear,
    output logic                locked,
    output logic                error_flag,
    output logic [CNT_W-1:0]    error_count,
    output logic [CNT_W-1:0]    bit_count,
    output logic [SHIFT_W-1:0]  lock_shift,
    output logic [RELOCK_W-1:0] relock_count
);

    // One extra bit lets all-ones stay above any real window total.
    localparam int                 ERR_W    = SHIFT_W + 1;
    localparam logic [SHIFT_W-1:0] LAST_IDX = SHIFT_W'(SEQ_LEN - 1);

    ber_state_e          r_state,      w_state_nxt;
    logic [SHIFT_W-1:0]  r_shift,      w_shift_nxt;
    logic [ERR_W-1:0]    r_best_err,   w_best_err_nxt;
    logic [SHIFT_W-1:0]  r_best_shift, w_best_shift_nxt;
    logic [SHIFT_W-1:0]  r_win_cnt,    w_win_cnt_nxt;
    logic [ERR_W-1:0]    r_win_err,    w_win_err_nxt;
    logic [SHIFT_W-1:0]  r_lock_shift, w_lock_shift_nxt;
    logic [CNT_W-1:0]    r_error_count;
    logic [CNT_W-1:0]    r_bit_count;
    logic [RELOCK_W-1:0] r_relock_count;

    logic                w_accept;
    logic [SHIFT_W-1:0]  w_sel;
    logic                w_tap;
    logic                w_e;
    logic [ERR_W-1:0]    w_total;
    logic                w_win_end;
    logic [ERR_W-1:0]    w_cand_err;
    logic [SHIFT_W-1:0]  w_cand_shift;
    logic                w_lost;

    assign w_accept  = enable & valid;
    assign w_sel     = (r_state == LOCK) ? r_lock_shift : r_shift;
    assign w_e       = w_tap ^ dx;
    assign w_total   = r_win_err + ERR_W'(w_e);
    assign w_win_end = (r_win_cnt == LAST_IDX);

    // Best-so-far including the window that is ending now.
    assign w_cand_err   = (w_total < r_best_err) ? w_total : r_best_err;
    assign w_cand_shift = (w_total < r_best_err) ? r_shift : r_best_shift;

    ber_tap_line #(
        .SEQ_LEN    (SEQ_LEN)
    ) u_tap_line (
        .clk        (clk),
        .reset      (reset),
        .i_shift_en (w_accept),
        .i_sx       (sx),
        .i_sel      (w_sel),
        .o_tap      (w_tap)
    );

    // Tracker state, sweep bookkeeping and window accumulators.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= HUNT;
            r_shift      <= '0;
            r_best_err   <= '1;
            r_best_shift <= '0;
            r_win_cnt    <= '0;
            r_win_err    <= '0;
            r_lock_shift <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_best_err   <= w_best_err_nxt;
            r_best_shift <= w_best_shift_nxt;
            r_win_cnt    <= w_win_cnt_nxt;
            r_win_err    <= w_win_err_nxt;
            r_lock_shift <= w_lock_shift_nxt;
        end
    end

    // Window accounting and HUNT/LOCK decisions taken at each window end.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_best_err_nxt   = r_best_err;
        w_best_shift_nxt = r_best_shift;
        w_win_cnt_nxt    = r_win_cnt;
        w_win_err_nxt    = r_win_err;
        w_lock_shift_nxt = r_lock_shift;
        w_lost           = 1'b0;

        if (w_accept) begin
            if (!w_win_end) begin
                w_win_cnt_nxt = r_win_cnt + SHIFT_W'(1);
                w_win_err_nxt = w_total;
            end else begin
                w_win_cnt_nxt = '0;
                w_win_err_nxt = '0;
                case (r_state)
                    HUNT: begin
                        if (w_total == '0) begin
                            // Error-free window: lock on this tap at once.
                            w_state_nxt      = LOCK;
                            w_lock_shift_nxt = r_shift;
                            w_shift_nxt      = '0;
                            w_best_err_nxt   = '1;
                        end else if (r_shift == LAST_IDX) begin
                            // Sweep complete: lock on the best tap if good enough.
                            w_shift_nxt      = '0;
                            w_best_err_nxt   = '1;
                            w_best_shift_nxt = '0;
                            if (int'(w_cand_err) <= LOCK_MAX_ERR) begin
                                w_state_nxt      = LOCK;
                                w_lock_shift_nxt = w_cand_shift;
                            end
                        end else begin
                            w_best_err_nxt   = w_cand_err;
                            w_best_shift_nxt = w_cand_shift;
                            w_shift_nxt      = r_shift + SHIFT_W'(1);
                        end
                    end
                    LOCK: begin
                        if (int'(w_total) > LOSS_ERR) begin
                            w_state_nxt    = HUNT;
                            w_shift_nxt    = '0;
                            w_best_err_nxt = '1;
                            w_lost         = 1'b1;
                        end
                    end
                    default: w_state_nxt = HUNT;
                endcase
            end
        end
    end

    // Saturating statistics; clear wins over any same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error_count  <= '0;
            r_bit_count    <= '0;
            r_relock_count <= '0;
        end else if (enable) begin
            if (clear) begin
                r_error_count  <= '0;
                r_bit_count    <= '0;
                r_relock_count <= '0;
            end else begin
                if (w_accept && (r_state == LOCK)) begin
                    if (r_bit_count != '1) begin
                        r_bit_count <= r_bit_count + CNT_W'(1);
                    end
                    if (w_e && (r_error_count != '1)) begin
                        r_error_count <= r_error_count + CNT_W'(1);
                    end
                end
                if (w_lost && (r_relock_count != '1)) begin
                    r_relock_count <= r_relock_count + RELOCK_W'(1);
                end
            end
        end
    end

    assign locked       = (r_state == LOCK);
    assign error_flag   = (r_error_count != '0);
    assign error_count  = r_error_count;
    assign bit_count    = r_bit_count;
    assign lock_shift   = r_lock_shift;
    assign relock_count = r_relock_count;

endmodule

// File: doc/ber_meter.md
BER_METER -- requirements
Module: ber_meter

Interface
REQ-001 Parameter SEQ_LEN, default 511: reference sequence period in bits, also the delay-line depth and the window length; legal range 3..4095.
REQ-002 Parameter CNT_W, default 64: width of error_count and bit_count.
REQ-003 Parameter LOCK_MAX_ERR, default 8: maximum best-window error count accepted as lock at end of a hunt sweep.
REQ-004 Parameter LOSS_ERR, default 64: window error count above which lock is declared lost.
REQ-005 Local SHIFT_W = clog2(SEQ_LEN).
REQ-006 clk  in  1  clock, all logic on rising edge.
REQ-007 reset  in  1  reset, asynchronous, active-high.
REQ-008 enable  in  1  global run enable; low freezes all state.
REQ-009 valid  in  1  sx/dx sample strobe.
REQ-010 sx  in  1  transmitted reference bit.
REQ-011 dx  in  1  received (decided) bit.
REQ-012 clear  in  1  synchronous clear of statistics counters.
REQ-013 locked  out  1  high while in LOCK state.
REQ-014 error_flag  out  1  high when error_count != 0.
REQ-015 error_count  out  CNT_W  errors accumulated in LOCK, saturating.
REQ-016 bit_count  out  CNT_W  bits compared in LOCK, saturating.
REQ-017 lock_shift  out  SHIFT_W  delay-line tap in use.
REQ-018 relock_count  out  16  number of loss-of-lock events, saturating.

Function
REQ-019 A sample is accepted on any cycle with enable & valid; nothing changes on other cycles.
REQ-020 Per accepted sample, sx shifts into a SEQ_LEN-bit delay line at index 0; tap k is the pre-update value of index k (sx delayed k+1 samples); e = tap[shift] XOR dx.
REQ-021 States: HUNT, LOCK; reset enters HUNT with shift = 0.
REQ-022 Window: SEQ_LEN accepted samples counted by win_cnt 0..SEQ_LEN-1; win_err accumulates e; end-of-window evaluation uses win_err + e of the last sample, then win_cnt and win_err return to 0.
REQ-023 HUNT end-of-window: if window total = 0, go to LOCK with lock_shift = shift immediately (fast path).
REQ-024 HUNT end-of-window otherwise: if total < best_err, record best_err/best_shift; shift increments.
REQ-025 HUNT at the end of the window for shift = SEQ_LEN-1: if the resulting best_err <= LOCK_MAX_ERR, go to LOCK with lock_shift = best_shift; otherwise restart the sweep at shift 0; best_err resets to all-ones in both cases.
REQ-026 LOCK: each accepted sample increments bit_count by 1 and error_count by e, using tap[lock_shift]; both counters saturate at all-ones.
REQ-027 LOCK end-of-window: if total > LOSS_ERR, go to HUNT at shift 0 and increment relock_count (saturating); error_count and bit_count hold.
REQ-028 clear has priority over the same-cycle increment: error_count, bit_count and relock_count go to 0; state, window and delay line are unaffected.
REQ-029 locked, error_flag and lock_shift are registered or derived from registers only; there is no combinational path from inputs to outputs.

Reset
REQ-030 On reset: delay line 0, state HUNT, shift 0, best_err all-ones, best_shift 0, win_cnt 0, win_err 0, lock_shift 0, all counters 0, locked 0, error_flag 0.
REQ-031 Reset asserted mid-window or mid-lock aborts immediately; no partial window is evaluated after release.

Structure
REQ-032 Package ber_pkg holds the state enum (HUNT, LOCK) and the default parameter constants.
REQ-033 Sub-module ber_tap_line: SEQ_LEN delay line plus tap-select mux; it outputs the selected tap.

Verification
REQ-034 SEQ_LEN=7, PRBS3 sx, dx = sx delayed 4 samples, no errors -> locked rises after sample 28, lock_shift=3, error_count stays 0.
REQ-035 As REQ-034, with dx inverted on one sample per 7 after lock -> error_count increments 1 per window, bit_count = samples since lock, locked stays 1 (LOSS_ERR=3).
REQ-036 LOSS_ERR=3, after lock invert 4 dx in one window -> locked falls at that window end, relock_count=1, relock within at most 2 sweeps.
REQ-037 Random dx uncorrelated to sx, LOCK_MAX_ERR=0 -> locked never asserts; sweeps restart at shift 0 every 49 samples.
REQ-038 clear asserted with an error sample in the same LOCK cycle -> error_count=0 and bit_count=0 next cycle; enable low for 10 cycles with valid high -> all outputs unchanged.
REQ-039 CNT_W=4 forced error stream -> error_count saturates at 15; reset pulse mid-window -> all REQ-030 values.
